// File: rtl/croc_pkg.sv
// croc_pkg: shared OBI types, address rule type and rule matching helper
package croc_pkg;

   localparam int unsigned SbrIdWidth    = 2;
   localparam int unsigned DemuxMaxTrans = 4;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_map_rule_t;

   typedef struct packed {
      logic [31:0]           addr;
      logic                  we;
      logic [3:0]            be;
      logic [31:0]           wdata;
      logic [SbrIdWidth-1:0] aid;
   } sbr_obi_a_chan_t;

   typedef struct packed {
      sbr_obi_a_chan_t a;
      logic            req;
   } sbr_obi_req_t;

   typedef struct packed {
      logic [31:0]           rdata;
      logic [SbrIdWidth-1:0] rid;
      logic                  err;
   } sbr_obi_r_chan_t;

   typedef struct packed {
      logic            gnt;
      logic            rvalid;
      sbr_obi_r_chan_t r;
   } sbr_obi_rsp_t;

   // Empty or inverted ranges never match; upper bound is exclusive.
   function automatic bit rule_match(logic [31:0] addr, addr_map_rule_t rule);
      return (rule.end_addr > rule.start_addr) && (addr >= rule.start_addr) && (addr < rule.end_addr);
   endfunction

endpackage

// File: rtl/croc_obi_err_sbr.sv
// croc_obi_err_sbr: error subordinate, grants always and answers err=1 one cycle later
module croc_obi_err_sbr import croc_pkg::*; #(
   parameter type obi_req_t = croc_pkg::sbr_obi_req_t,
   parameter type obi_rsp_t = croc_pkg::sbr_obi_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  obi_req_t req_i,
   output obi_rsp_t rsp_o
);

   obi_rsp_t rsp_d, rsp_q;

   // Build next-cycle error response from this cycle's request
   always_comb begin
      rsp_d          = '0;
      rsp_d.rvalid   = req_i.req;
      rsp_d.r.err    = req_i.req;
      rsp_d.r.rid    = req_i.req ? req_i.a.aid : '0;
   end

   // One-deep response pipeline, sustains one transaction per cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rsp_q <= '0;
      else       rsp_q <= rsp_d;
   end

   // Grant is unconditional
   always_comb begin
      rsp_o     = rsp_q;
      rsp_o.gnt = 1'b1;
   end

endmodule

// File: rtl/croc_obi_rule_demux.sv
// croc_obi_rule_demux: OBI demux with run-time rule table, error subordinate and in-order tracking (optional CROC_DEMUX_ERR_CNT_EN)
module croc_obi_rule_demux import croc_pkg::*; #(
   parameter int unsigned NumSbr   = 4,
   parameter int unsigned NumRules = 3,
   parameter int unsigned MaxTrans = croc_pkg::DemuxMaxTrans,
   parameter type obi_req_t = croc_pkg::sbr_obi_req_t,
   parameter type obi_rsp_t = croc_pkg::sbr_obi_rsp_t
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  addr_map_rule_t rules_i   [NumRules],
   input  obi_req_t       mgr_req_i,
   output obi_rsp_t       mgr_rsp_o,
   output obi_req_t       sbr_req_o [NumSbr],
   input  obi_rsp_t       sbr_rsp_i [NumSbr]
`ifdef CROC_DEMUX_ERR_CNT_EN
   ,output logic [15:0]   err_cnt_o
`endif
);

   localparam int unsigned SelW = $clog2(NumSbr + 1);
   localparam int unsigned CntW = $clog2(MaxTrans + 1);
   localparam logic [SelW-1:0] Err = SelW'(NumSbr);

   logic [CntW-1:0] cnt_d, cnt_q;
   logic [SelW-1:0] sel_d, sel_q, tgt;
   logic            fwd, hs, rv;
   obi_req_t        err_req;
   obi_rsp_t        err_rsp;
   obi_rsp_t        rsp_all [NumSbr+1];

   // Priority decode: iterate downwards so the lowest matching rule wins
   always_comb begin
      tgt = Err;
      for (int r = NumRules - 1; r >= 0; r--)
         if (rule_match(mgr_req_i.a.addr, rules_i[r]) && rules_i[r].idx < 32'(NumSbr))
            tgt = rules_i[r].idx[SelW-1:0];
   end

   assign fwd = mgr_req_i.req && (cnt_q == '0 || tgt == sel_q) && cnt_q < CntW'(MaxTrans);
   assign hs  = mgr_req_i.req && mgr_rsp_o.gnt;
   assign rv  = mgr_rsp_o.rvalid;

   // Gather subordinate responses with ERR as the last entry
   always_comb begin
      for (int i = 0; i < NumSbr; i++) rsp_all[i] = sbr_rsp_i[i];
      rsp_all[NumSbr] = err_rsp;
   end

   // Forward the request only to the decoded target
   always_comb begin
      for (int i = 0; i < NumSbr; i++) sbr_req_o[i] = (fwd && tgt == SelW'(i)) ? mgr_req_i : '0;
      err_req     = mgr_req_i;
      err_req.req = fwd && tgt == Err;
   end

   // Grant from decoded target; response only from the locked target while busy
   always_comb begin
      mgr_rsp_o        = '0;
      mgr_rsp_o.gnt    = fwd && rsp_all[tgt].gnt;
      mgr_rsp_o.rvalid = cnt_q != '0 && rsp_all[sel_q].rvalid;
      mgr_rsp_o.r      = cnt_q != '0 ? rsp_all[sel_q].r : '0;
   end

   croc_obi_err_sbr #(
      .obi_req_t (obi_req_t),
      .obi_rsp_t (obi_rsp_t)
   ) u_err (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (err_req),
      .rsp_o (err_rsp)
   );

   assign cnt_d = cnt_q + CntW'(hs) - CntW'(rv);
   assign sel_d = hs ? tgt : sel_q;

   // Outstanding count and locked target
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         sel_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         sel_q <= sel_d;
      end
   end

`ifdef CROC_DEMUX_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   // Saturating count of handshakes with the error subordinate
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_cnt_q <= '0;
      else       err_cnt_q <= (hs && tgt == Err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_croc_obi_rule_demux.sv
// tb_croc_obi_rule_demux: directed self-checking bench for croc_obi_rule_demux
module tb_croc_obi_rule_demux;
   import croc_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   addr_map_rule_t rules   [3];
   sbr_obi_req_t   mgr_req;
   sbr_obi_rsp_t   mgr_rsp;
   sbr_obi_req_t   sbr_req [4];
   sbr_obi_rsp_t   sbr_rsp [4];
`ifdef CROC_DEMUX_ERR_CNT_EN
   logic [15:0]    err_cnt;
`endif
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   croc_obi_rule_demux dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .rules_i   (rules),
      .mgr_req_i (mgr_req),
      .mgr_rsp_o (mgr_rsp),
      .sbr_req_o (sbr_req),
      .sbr_rsp_i (sbr_rsp)
`ifdef CROC_DEMUX_ERR_CNT_EN
      ,.err_cnt_o (err_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] addr, input logic [1:0] aid);
      mgr_req        = '0;
      mgr_req.req    = 1'b1;
      mgr_req.a.addr = addr;
      mgr_req.a.aid  = aid;
      mgr_req.a.be   = '1;
   endtask

   task automatic idle;
      mgr_req = '0;
   endtask

   task automatic rsp(input int p, input logic [31:0] d, input logic [1:0] id);
      sbr_rsp[p].rvalid  = 1'b1;
      sbr_rsp[p].r.rdata = d;
      sbr_rsp[p].r.rid   = id;
   endtask

   task automatic clr_rsp;
      for (int i = 0; i < 4; i++) begin
         sbr_rsp[i]     = '0;
         sbr_rsp[i].gnt = 1'b1;
      end
   endtask

   function automatic logic [3:0] reqs;
      return {sbr_req[3].req, sbr_req[2].req, sbr_req[1].req, sbr_req[0].req};
   endfunction

   initial begin
      rst = 1'b1;
      rules[0] = '{idx: 32'd1, start_addr: 32'h0000_0000, end_addr: 32'h1000_0000};
      rules[1] = '{idx: 32'd2, start_addr: 32'h1000_0000, end_addr: 32'h1000_1000};
      rules[2] = '{idx: 32'd3, start_addr: 32'h2000_0000, end_addr: 32'h8000_0000};
      clr_rsp;
      idle;
      tick;
      tick;
      check("rst_cnt", 64'(dut.cnt_q), 0);
      check("rst_mgr_rsp", 64'(mgr_rsp), 0);
      check("rst_sbr_req", 64'(reqs()), 0);
      rst = 1'b0;
      tick;
      // scenario 1: range boundaries of r1
      rd(32'h1000_0FFC, 2'd1);
      #1;
      check("s1_route_p2", 64'(reqs()), 4'b0100);
      check("s1_addr_p2", 64'(sbr_req[2].a.addr), 32'h1000_0FFC);
      check("s1_gnt", 64'(mgr_rsp.gnt), 1);
      tick;
      idle;
      check("s1_cnt1", 64'(dut.cnt_q), 1);
      rsp(2, 32'hAB, 2'd1);
      #1;
      check("s1_rvalid", 64'(mgr_rsp.rvalid), 1);
      check("s1_rdata", 64'(mgr_rsp.r.rdata), 32'hAB);
      check("s1_rid", 64'(mgr_rsp.r.rid), 1);
      tick;
      clr_rsp;
      check("s1_cnt0", 64'(dut.cnt_q), 0);
      rd(32'h1000_1000, 2'd2);
      #1;
      check("s1_err_noreq", 64'(reqs()), 0);
      check("s1_err_gnt", 64'(mgr_rsp.gnt), 1);
      check("s1_err_rv_early", 64'(mgr_rsp.rvalid), 0);
      tick;
      idle;
      #1;
      check("s1_err_rvalid", 64'(mgr_rsp.rvalid), 1);
      check("s1_err_err", 64'(mgr_rsp.r.err), 1);
      check("s1_err_rdata", 64'(mgr_rsp.r.rdata), 0);
      check("s1_err_rid", 64'(mgr_rsp.r.rid), 2);
      tick;
      #1;
      check("s1_err_done_rv", 64'(mgr_rsp.rvalid), 0);
      check("s1_err_done_cnt", 64'(dut.cnt_q), 0);
      // scenario 2: outstanding limit
      rd(32'h0300_0000, 2'd0);
      repeat (4) tick;
      check("s2_cnt_peak", 64'(dut.cnt_q), 4);
      #1;
      check("s2_full_gnt", 64'(mgr_rsp.gnt), 0);
      check("s2_full_req", 64'(reqs()), 0);
      rsp(1, 32'h5, 2'd0);
      #1;
      check("s2_rv_fwd", 64'(mgr_rsp.rvalid), 1);
      check("s2_rv_gnt", 64'(mgr_rsp.gnt), 0);
      tick;
      clr_rsp;
      check("s2_cnt3", 64'(dut.cnt_q), 3);
      #1;
      check("s2_regnt", 64'(mgr_rsp.gnt), 1);
      tick;
      idle;
      check("s2_cnt4", 64'(dut.cnt_q), 4);
      rsp(1, 32'h5, 2'd0);
      repeat (4) tick;
      clr_rsp;
      check("s2_drain", 64'(dut.cnt_q), 0);
      // scenario 3: target switch waits for the old target's response
      rd(32'h0000_0000, 2'd0);
      tick;
      rd(32'h1000_0000, 2'd1);
      #1;
      check("s3_hold_req", 64'(reqs()), 0);
      check("s3_hold_gnt", 64'(mgr_rsp.gnt), 0);
      rsp(1, 32'h11, 2'd0);
      #1;
      check("s3_rv1", 64'(mgr_rsp.rvalid), 1);
      check("s3_rdata1", 64'(mgr_rsp.r.rdata), 32'h11);
      check("s3_rv_gnt", 64'(mgr_rsp.gnt), 0);
      tick;
      clr_rsp;
      #1;
      check("s3_switch_req", 64'(reqs()), 4'b0100);
      check("s3_switch_gnt", 64'(mgr_rsp.gnt), 1);
      tick;
      idle;
      rsp(2, 32'h22, 2'd1);
      #1;
      check("s3_rdata2", 64'(mgr_rsp.r.rdata), 32'h22);
      check("s3_rid2", 64'(mgr_rsp.r.rid), 1);
      tick;
      clr_rsp;
      check("s3_cnt0", 64'(dut.cnt_q), 0);
      // scenario 4: asynchronous reset with outstanding transactions
      rd(32'h0000_0000, 2'd0);
      tick;
      tick;
      idle;
      check("s4_cnt2", 64'(dut.cnt_q), 2);
      #2;
      rst = 1'b1;
      #1;
      check("s4_async_cnt", 64'(dut.cnt_q), 0);
      tick;
      rst = 1'b0;
      rsp(1, 32'h33, 2'd0);
      #1;
      check("s4_stale_rv", 64'(mgr_rsp.rvalid), 0);
      tick;
      clr_rsp;
      check("s4_stale_cnt", 64'(dut.cnt_q), 0);
      rd(32'hF000_0000, 2'd3);
      tick;
      idle;
      rst = 1'b1;
      #1;
      check("s4_err_flush", 64'(dut.u_err.rsp_o.rvalid), 0);
      tick;
      rst = 1'b0;
      // scenario 5: rule table changes, disabled/overlapping/out-of-range rules
      rules[1].end_addr = 32'h0;
      rules[0].end_addr = 32'h2000_0000;
      rd(32'h1000_0000, 2'd0);
      #1;
      check("s5_disabled_r1", 64'(reqs()), 4'b0010);
      rules[1].end_addr = 32'h1000_1000;
      #1;
      check("s5_overlap_low", 64'(reqs()), 4'b0010);
      rules[2].idx = 32'd4;
      rd(32'h3000_0000, 2'd0);
      #1;
      check("s5_bad_idx_req", 64'(reqs()), 0);
      check("s5_bad_idx_gnt", 64'(mgr_rsp.gnt), 1);
      idle;
      rules[2].idx = 32'd3;
      rd(32'h9000_0000, 2'd1);
      repeat (3) tick;
      idle;
      check("s5_err_cnt_busy", 64'(dut.cnt_q), 1);
      tick;
      check("s5_err_cnt_done", 64'(dut.cnt_q), 0);
`ifdef CROC_DEMUX_ERR_CNT_EN
      check("s5_err_cnt_o", 64'(err_cnt), 3);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
